branch_resolve_unit: RTL and testbench

- EX-stage counterpart to the IF-stage gshare predictor.
- Carries each fetched instruction's prediction metadata (predicted next PC, PHT index) down the IF/ID and ID/EX pipeline registers.
- Resolves the actual control-flow outcome in EX and produces the redirect/flush signals.
- Drives the predictor's update interface: is_branch, is_jal, is_jalr, actual_taken, actual_branch_target, prediction_correct, pht_update_index, ID_EX_pc.
- Keeps saturating performance counters.

---
 rtl/branch_resolve_unit.sv | 128 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: carries gshare prediction metadata through IF/ID and ID/EX,
// resolves the real next PC, raises redirect/flush and feeds the predictor update port.
module branch_resolve_unit #(
    parameter int PHT_BITS  = 5,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_valid,
    input  logic [31:0]          if_pc,
    input  logic [31:0]          if_pred_next_pc,
    input  logic [PHT_BITS-1:0]  if_pht_index,
    input  logic                 stall,
    input  logic                 ex_is_branch,
    input  logic                 ex_is_jal,
    input  logic                 ex_is_jalr,
    input  logic                 ex_branch_cond,
    input  logic [31:0]          ex_imm_target,
    input  logic [31:0]          ex_jalr_target,
    output logic                 is_branch,
    output logic                 is_jal,
    output logic                 is_jalr,
    output logic                 actual_taken,
    output logic [31:0]          actual_branch_target,
    output logic                 prediction_correct,
    output logic [PHT_BITS-1:0]  pht_update_index,
    output logic [31:0]          ID_EX_pc,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic                 flush,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    typedef struct packed {
        logic                vld;
        logic [31:0]         pc;
        logic [31:0]         pred;
        logic [PHT_BITS-1:0] pht;
    } stage_t;

    stage_t               ifid_q, ifid_d, idex_q, idex_d;
    logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;

    logic        v, ctl, taken, correct, mispredict;
    logic [31:0] seq_pc, jalr_tgt, tgt, next_pc;

    // Resolution: branch > jal > jalr when the decode flags overlap.
    always_comb begin
        v        = idex_q.vld;
        seq_pc   = idex_q.pc + 32'd4;
        jalr_tgt = ex_jalr_target & ~32'h1;
        tgt      = '0;
        taken    = 1'b0;
        next_pc  = seq_pc;
        if (ex_is_branch) begin
            tgt   = ex_imm_target;
            taken = ex_branch_cond;
            if (ex_branch_cond) next_pc = ex_imm_target;
        end else if (ex_is_jal) begin
            tgt     = ex_imm_target;
            taken   = 1'b1;
            next_pc = ex_imm_target;
        end else if (ex_is_jalr) begin
            tgt     = jalr_tgt;
            taken   = 1'b1;
            next_pc = jalr_tgt;
        end
        ctl        = ex_is_branch | ex_is_jal | ex_is_jalr;
        correct    = (idex_q.pred == next_pc);
        mispredict = v & ~correct;
    end

    // Everything is gated by ID/EX valid so bubbles and post-reset cycles read as zero.
    assign is_branch            = v & ex_is_branch;
    assign is_jal               = v & ex_is_jal;
    assign is_jalr              = v & ex_is_jalr;
    assign actual_taken         = v & taken;
    assign actual_branch_target = v ? tgt : 32'd0;
    assign prediction_correct   = v & correct;
    assign pht_update_index     = v ? idex_q.pht : '0;
    assign ID_EX_pc             = v ? idex_q.pc : 32'd0;
    assign redirect_valid       = mispredict;
    assign flush                = mispredict;
    assign redirect_pc          = v ? next_pc : 32'd0;
    assign branch_count         = bcnt_q;
    assign mispredict_count     = mcnt_q;

    always_comb begin
        ifid_d = ifid_q;
        idex_d = idex_q;
        if (mispredict) begin
            ifid_d.vld = 1'b0;
            idex_d.vld = 1'b0;
        end else if (stall) begin
            idex_d.vld = 1'b0;
        end else begin
            ifid_d.vld  = if_valid;
            ifid_d.pc   = if_pc;
            ifid_d.pred = if_pred_next_pc;
            ifid_d.pht  = if_pht_index;
            idex_d      = ifid_q;
        end
    end

    // Saturating counters: stop at all-ones instead of wrapping.
    always_comb begin
        bcnt_d = bcnt_q;
        mcnt_d = mcnt_q;
        if (v && ctl && !(&bcnt_q)) bcnt_d = bcnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        if (mispredict && !(&mcnt_q)) mcnt_d = mcnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_q <= '0;
            idex_q <= '0;
            bcnt_q <= '0;
            mcnt_q <= '0;
        end else begin
            ifid_q <= ifid_d;
            idex_q <= idex_d;
            bcnt_q <= bcnt_d;
            mcnt_q <= mcnt_d;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: fetched instructions go into a scoreboard
// and are popped and checked against a reference resolution when they reach EX.
module tb_branch_resolve_unit;
    localparam int PB = 5;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_valid, stall;
    logic [31:0]   if_pc, if_pred_next_pc;
    logic [PB-1:0] if_pht_index;
    logic          ex_is_branch, ex_is_jal, ex_is_jalr, ex_branch_cond;
    logic [31:0]   ex_imm_target, ex_jalr_target;
    logic          is_branch, is_jal, is_jalr, actual_taken, prediction_correct;
    logic [31:0]   actual_branch_target, ID_EX_pc, redirect_pc;
    logic [PB-1:0] pht_update_index;
    logic          redirect_valid, flush;
    logic [CW-1:0] branch_count, mispredict_count;

    branch_resolve_unit #(.PHT_BITS(PB), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
        .if_pred_next_pc(if_pred_next_pc), .if_pht_index(if_pht_index), .stall(stall),
        .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_branch_cond(ex_branch_cond), .ex_imm_target(ex_imm_target),
        .ex_jalr_target(ex_jalr_target), .is_branch(is_branch), .is_jal(is_jal),
        .is_jalr(is_jalr), .actual_taken(actual_taken),
        .actual_branch_target(actual_branch_target), .prediction_correct(prediction_correct),
        .pht_update_index(pht_update_index), .ID_EX_pc(ID_EX_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]   pc;
        logic [31:0]   pred;
        logic [PB-1:0] pht;
    } fetch_t;

    fetch_t        sbq[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [CW-1:0] exp_bc, exp_mc;
    logic          pend_b, pend_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic v, input logic [31:0] pc, input logic [31:0] pred,
                         input logic [PB-1:0] pht);
        if_valid = v; if_pc = pc; if_pred_next_pc = pred; if_pht_index = pht;
        if (v) sbq.push_back('{pc: pc, pred: pred, pht: pht});
    endtask

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pend_b && exp_bc != {CW{1'b1}}) exp_bc = exp_bc + 1'b1;
        if (pend_m && exp_mc != {CW{1'b1}}) exp_mc = exp_mc + 1'b1;
        pend_b = 1'b0;
        pend_m = 1'b0;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, ".branch_count"}, 32'(branch_count), 32'(exp_bc));
        chk({tag, ".mispredict_count"}, 32'(mispredict_count), 32'(exp_mc));
    endtask

    // EX holds no valid instruction: drive busy ex_* values and expect all-zero outputs.
    task automatic chk_idle(input string tag);
        ex_is_branch = 1'b1; ex_is_jal = 1'b0; ex_is_jalr = 1'b0; ex_branch_cond = 1'b1;
        ex_imm_target = 32'h55; ex_jalr_target = 32'h77;
        #1;
        chk({tag, ".is_branch"}, 32'(is_branch), 32'd0);
        chk({tag, ".actual_taken"}, 32'(actual_taken), 32'd0);
        chk({tag, ".target"}, actual_branch_target, 32'd0);
        chk({tag, ".correct"}, 32'(prediction_correct), 32'd0);
        chk({tag, ".pht"}, 32'(pht_update_index), 32'd0);
        chk({tag, ".pc"}, ID_EX_pc, 32'd0);
        chk({tag, ".redirect"}, 32'(redirect_valid), 32'd0);
        chk({tag, ".redirect_pc"}, redirect_pc, 32'd0);
        chk({tag, ".flush"}, 32'(flush), 32'd0);
    endtask

    // kind: 0 none, 1 branch, 2 jal, 3 jalr. Pops the oldest fetch and checks resolution.
    task automatic resolve(input string tag, input int kind, input logic cond,
                           input logic [31:0] imm, input logic [31:0] jalr);
        fetch_t      f;
        logic [31:0] nxt, tgt;
        logic        tk, ok;
        n_cmp++;
        assert (sbq.size() > 0) else begin
            n_err++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end
        if (sbq.size() == 0) return;
        f = sbq.pop_front();
        ex_is_branch = (kind == 1); ex_is_jal = (kind == 2); ex_is_jalr = (kind == 3);
        ex_branch_cond = cond; ex_imm_target = imm; ex_jalr_target = jalr;
        nxt = f.pc + 32'd4; tgt = 32'd0; tk = 1'b0;
        case (kind)
            1: begin tgt = imm; tk = cond; if (cond) nxt = imm; end
            2: begin tgt = imm; tk = 1'b1; nxt = imm; end
            3: begin tgt = jalr & 32'hFFFF_FFFE; tk = 1'b1; nxt = tgt; end
            default: ;
        endcase
        ok = (f.pred == nxt);
        #1;
        chk({tag, ".is_branch"}, 32'(is_branch), 32'(kind == 1));
        chk({tag, ".is_jal"}, 32'(is_jal), 32'(kind == 2));
        chk({tag, ".is_jalr"}, 32'(is_jalr), 32'(kind == 3));
        chk({tag, ".actual_taken"}, 32'(actual_taken), 32'(tk));
        if (kind != 0) chk({tag, ".target"}, actual_branch_target, tgt);
        chk({tag, ".correct"}, 32'(prediction_correct), 32'(ok));
        chk({tag, ".pht"}, 32'(pht_update_index), 32'(f.pht));
        chk({tag, ".pc"}, ID_EX_pc, f.pc);
        chk({tag, ".redirect"}, 32'(redirect_valid), 32'(!ok));
        chk({tag, ".flush"}, 32'(flush), 32'(!ok));
        chk({tag, ".redirect_pc"}, redirect_pc, nxt);
        pend_b = (kind != 0);
        pend_m = !ok;
    endtask

    // Fetch one instruction, let it travel two cycles, then resolve it.
    task automatic run_one(input string tag, input logic [31:0] pc, input logic [31:0] pred,
                           input logic [PB-1:0] pht, input int kind, input logic cond,
                           input logic [31:0] imm, input logic [31:0] jalr);
        fetch(1'b1, pc, pred, pht);
        tick();
        fetch(1'b0, 32'd0, 32'd0, '0);
        tick();
        resolve(tag, kind, cond, imm, jalr);
        tick();
        if (redirect_valid === 1'b0 && pend_m) sbq.delete();
        sbq.delete();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; pend_b = 1'b0; pend_m = 1'b0; exp_bc = '0; exp_mc = '0;
        fetch(1'b0, 32'd0, 32'd0, '0);
        #2;
        chk_idle("in_reset");
        chk_cnt("in_reset");
        tick();
        reset = 1'b0;
        chk_idle("post_reset");
        chk_cnt("post_reset");

        run_one("br_ok", 32'h100, 32'h140, 5'h13, 1, 1'b1, 32'h140, 32'h0);
        chk_cnt("br_ok");

        // Mispredicted branch with younger fetches behind it: all get squashed.
        fetch(1'b1, 32'h100, 32'h140, 5'h13); tick();
        fetch(1'b1, 32'h500, 32'h504, 5'h07); tick();
        fetch(1'b1, 32'h600, 32'h604, 5'h08);
        resolve("br_mis", 1, 1'b0, 32'h140, 32'h0);
        tick(); sbq.delete();
        fetch(1'b0, 32'd0, 32'd0, '0);
        chk_idle("br_mis_sq1");
        chk_cnt("br_mis");
        tick();
        chk_idle("br_mis_sq2");

        run_one("jalr", 32'h200, 32'h204, 5'h05, 3, 1'b0, 32'h0, 32'h301);
        chk_cnt("jalr");
        run_one("jal_ok", 32'h300, 32'h400, 5'h02, 2, 1'b0, 32'h400, 32'h0);
        chk_cnt("jal_ok");

        // Two stall cycles with a branch waiting in IF/ID.
        fetch(1'b1, 32'h700, 32'h780, 5'h1A); tick();
        fetch(1'b0, 32'd0, 32'd0, '0);
        stall = 1'b1; tick();
        chk_idle("stall_b1");
        tick();
        chk_idle("stall_b2");
        stall = 1'b0; tick();
        resolve("stall_br", 1, 1'b1, 32'h780, 32'h0);
        tick();
        chk_cnt("stall_br");

        // Stall and mispredict together: flush must squash IF/ID as well.
        fetch(1'b1, 32'h800, 32'h804, 5'h11); tick();
        fetch(1'b1, 32'h900, 32'h904, 5'h12); tick();
        fetch(1'b0, 32'd0, 32'd0, '0);
        stall = 1'b1;
        resolve("stall_mis", 1, 1'b1, 32'h840, 32'h0);
        tick(); sbq.delete();
        stall = 1'b0;
        chk_idle("stall_mis_sq1");
        tick();
        chk_idle("stall_mis_sq2");
        chk_cnt("stall_mis");

        run_one("alias", 32'h1000, 32'h2000, 5'h03, 0, 1'b0, 32'h0, 32'h0);
        chk_cnt("alias");

        for (int i = 0; i < 9; i++) begin
            run_one($sformatf("sat%0d", i), 32'h40 * i, 32'h4000, 5'(i), 1, 1'b0, 32'h4000, 32'h0);
            chk_cnt($sformatf("sat%0d", i));
        end

        // Reset while a valid instruction sits in ID/EX.
        fetch(1'b1, 32'h3000, 32'h3100, 5'h09); tick();
        fetch(1'b0, 32'd0, 32'd0, '0); tick();
        reset = 1'b1;
        sbq.delete(); exp_bc = '0; exp_mc = '0; pend_b = 1'b0; pend_m = 1'b0;
        chk_idle("mid_reset");
        chk_cnt("mid_reset");
        tick();
        reset = 1'b0;
        pend_b = 1'b0; pend_m = 1'b0;
        chk_idle("mid_reset_rel");
        fetch(1'b1, 32'h4000, 32'h4004, 5'h01); tick();
        fetch(1'b0, 32'd0, 32'd0, '0);
        chk_idle("lat_1cyc");
        tick();
        resolve("lat_2cyc", 0, 1'b0, 32'h0, 32'h0);
        tick();
        chk_cnt("lat_2cyc");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
